// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with sync, blanking, strobes and frame counter
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               sync_restart,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);
    localparam logic [X_W:0] H_ACT = (X_W+1)'(H_DISPLAY);
    localparam logic [X_W:0] HS_BEG = (X_W+1)'(H_DISPLAY + H_FRONT);
    localparam logic [X_W:0] HS_END = (X_W+1)'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [Y_W:0] V_ACT = (Y_W+1)'(V_DISPLAY);
    localparam logic [Y_W:0] VS_BEG = (Y_W+1)'(V_DISPLAY + V_FRONT);
    localparam logic [Y_W:0] VS_END = (Y_W+1)'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [X_W-1:0] x_n;
    logic [Y_W-1:0] y_n;
    logic [X_W:0]   xe;
    logic [Y_W:0]   ye;
    logic           x_wrap, frame_n, hs_n, vs_n, act_n;
    logic           first;

    // Decodes are taken from the next counter values so sync/blank land on the same edge as x/y.
    always_comb begin
        x_wrap  = x == X_LAST;
        x_n     = x_wrap ? '0 : x + 1'b1;
        y_n     = x_wrap ? ((y == Y_LAST) ? '0 : y + 1'b1) : y;
        xe      = {1'b0, x_n};
        ye      = {1'b0, y_n};
        frame_n = (x_n == '0) && (y_n == '0);
        hs_n    = (xe >= HS_BEG && xe < HS_END) ? H_POL : !H_POL;
        vs_n    = (ye >= VS_BEG && ye < VS_END) ? V_POL : !V_POL;
        act_n   = (xe < H_ACT) && (ye < V_ACT);
    end

    // first suppresses the frame count on the wrap that follows reset or restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= X_LAST;
            y           <= Y_LAST;
            hsync       <= !H_POL;
            vsync       <= !V_POL;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            first       <= 1'b1;
        end else if (sync_restart) begin
            x           <= X_LAST;
            y           <= Y_LAST;
            hsync       <= !H_POL;
            vsync       <= !V_POL;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            first       <= 1'b1;
        end else if (ce) begin
            x           <= x_n;
            y           <= y_n;
            hsync       <= hs_n;
            vsync       <= vs_n;
            active      <= act_n;
            line_start  <= x_n == '0;
            frame_start <= frame_n;
            if (frame_n) begin
                first <= 1'b0;
                if (!first) frame_cnt <= frame_cnt + 1'b1;
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench on a small 15x7 mode with active-high syncs and a 2-bit frame counter
module tb_vga_timing_gen;
    localparam int HT = 15;
    localparam int VT = 7;
    localparam int FT = HT * VT;

    logic       clk = 1'b0, rst_n = 1'b0, ce = 1'b0, sync_restart = 1'b0;
    logic [3:0] x;
    logic [2:0] y;
    logic       hsync, vsync, active, line_start, frame_start;
    logic [1:0] frame_cnt;

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(1'b1), .V_POL(1'b1), .X_W(4), .Y_W(3), .FRAME_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sync_restart(sync_restart),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync), .active(active),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         phase;
        logic [3:0] x;
        logic [2:0] y;
        logic       hs, vs, act, ls, fs;
        logic [1:0] fc;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0, phase = 0;
    int   p = FT - 1, fc = 0;
    bit   first = 1'b1, ls = 1'b0, fs = 1'b0;

    // Linear raster position p = y*HT + x; the reset/restart state coincides with p = FT-1.
    function automatic exp_t cur();
        exp_t e;
        int cx = p % HT, cy = p / HT;
        e.phase = phase;
        e.x     = 4'(cx);
        e.y     = 3'(cy);
        e.hs    = cx >= 10 && cx <= 12;
        e.vs    = cy == 5;
        e.act   = cx < 8 && cy < 4;
        e.ls    = ls;
        e.fs    = fs;
        e.fc    = 2'(fc);
        return e;
    endfunction

    task automatic step(input bit c, input bit r, input bit rl);
        @(negedge clk);
        ce = c; sync_restart = r; rst_n = !rl;
        @(posedge clk);
        #1;
        if (rl) begin
            p = FT - 1; first = 1'b1; fc = 0; ls = 1'b0; fs = 1'b0;
        end else if (r) begin
            p = FT - 1; first = 1'b1; ls = 1'b0; fs = 1'b0;
        end else if (c) begin
            p  = (p + 1) % FT;
            ls = (p % HT) == 0;
            fs = p == 0;
            if (fs) begin
                if (!first) fc = (fc + 1) % 4;
                first = 1'b0;
            end
        end else begin
            ls = 1'b0; fs = 1'b0;
        end
        q.push_back(cur());
    endtask

    task automatic chk(input string name, input int act_v, input int exp_v);
        total++;
        if (act_v != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (x !== e.x || y !== e.y || hsync !== e.hs || vsync !== e.vs || active !== e.act ||
                line_start !== e.ls || frame_start !== e.fs || frame_cnt !== e.fc) begin
                bad++;
                $display("FAIL raster phase %0d: got x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d want x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d",
                         e.phase, x, y, hsync, vsync, active, line_start, frame_start, frame_cnt,
                         e.x, e.y, e.hs, e.vs, e.act, e.ls, e.fs, e.fc);
            end
        end
    end

    initial begin
        phase = 0;
        repeat (3) step(1'b1, 1'b0, 1'b1);
        phase = 1;
        repeat (2 * FT + 1) step(1'b1, 1'b0, 1'b0);
        phase = 2;
        for (int i = 0; i < 4 * HT; i++) step(i % 2 == 0, 1'b0, 1'b0);
        phase = 3;
        while (p != 2 * HT + 11) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        phase = 4;
        repeat (5 * FT + 20) step(1'b1, 1'b0, 1'b0);
        phase = 5;
        while (p % HT != 11) step(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("pre_reset_hsync", int'(hsync), 1);
        rst_n = 1'b0;
        #1;
        chk("async_x", int'(x), 14);
        chk("async_y", int'(y), 6);
        chk("async_hsync", int'(hsync), 0);
        chk("async_vsync", int'(vsync), 0);
        chk("async_active", int'(active), 0);
        chk("async_frame_cnt", int'(frame_cnt), 0);
        phase = 6;
        repeat (2) step(1'b1, 1'b0, 1'b1);
        repeat (HT + 3) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) chk("scoreboard_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
